// File: rtl/bsg_cgol_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bsg_cgol_pkg
// Purpose : Shared definitions for the Game-of-Life cell array interfaces:
//           reader/loader state encodings, the word-count helper shared by
//           the board loader and board reader, and row-major cell indexing.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package bsg_cgol_pkg;

  // Reader/loader FSM states.
  typedef enum logic [0:0] {
    CGOL_IDLE = 1'b0,
    CGOL_SEND = 1'b1
  } cgol_state_e;

  // Explicit-width encodings used by the state registers.
  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_SEND = 1'b1;

  // Row-major convention: cell (row, col) lives at bit row*board_width + col.
  localparam int CGOL_ROW_STRIDE_CELLS = 1;  // stride multiplier applied to board_width per row
  localparam int CGOL_COL_STRIDE_CELLS = 1;  // adjacent columns are adjacent bits

  function automatic int cgol_cell_idx(input int row, input int col, input int board_width);
    return row * board_width * CGOL_ROW_STRIDE_CELLS + col * CGOL_COL_STRIDE_CELLS;
  endfunction

  // Number of width-bit words needed to carry a square board.
  function automatic int cgol_num_words(input int board_width, input int width);
    return (board_width * board_width + width - 1) / width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_counter_clear_up.sv
`default_nettype none
// ============================================================================
// Module  : bsg_counter_clear_up
// Purpose : Up-counter with synchronous clear and asynchronous active-low
//           reset. Clear has priority over increment; increment saturates
//           at max_val_p so the count can never leave [0, max_val_p].
// Ports   : clk_i      - clock
//           reset_n_i  - asynchronous active-low reset (count -> 0)
//           clear_i    - synchronous clear to 0
//           up_i       - increment by one
//           count_o    - current count
// Revision: 1.0 - initial release
// ============================================================================
module bsg_counter_clear_up #(
  parameter int max_val_p = 7,
  parameter int width_p   = (max_val_p > 0) ? $clog2(max_val_p + 1) : 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

  logic [width_p-1:0] count_d;
  logic [width_p-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (up_i && (count_q != max_lp)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/bsg_cgol_board_reader.sv
`default_nettype none
// ============================================================================
// Module  : bsg_cgol_board_reader
// Purpose : Snapshots the whole cell array in one cycle on request and
//           streams it out as width_p-bit words (lowest cell indices first)
//           over a valid/yumi handshake. The final word is zero-padded.
// Ports   : clk_i      - clock
//           reset_n_i  - asynchronous active-low reset
//           data_i     - cell states, bit row*board_width_p + col
//           v_i        - capture request, honoured only while ready_o
//           ready_o    - idle and able to capture (registered)
//           data_o     - current output word
//           v_o        - data_o valid
//           yumi_i     - consumer takes the current word
//           last_o     - current word is the last of the frame
// Revision: 1.0 - initial release
// ============================================================================
module bsg_cgol_board_reader
  import bsg_cgol_pkg::*;
#(
  parameter int board_width_p = 8,
  parameter int width_p       = 8
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [board_width_p*board_width_p-1:0] data_i,
  input  logic                                   v_i,
  output logic                                   ready_o,
  output logic [width_p-1:0]                     data_o,
  output logic                                   v_o,
  input  logic                                   yumi_i,
  output logic                                   last_o
);

  localparam int n_lp         = board_width_p * board_width_p;
  localparam int num_words_lp = cgol_num_words(board_width_p, width_p);
  localparam int pad_width_lp = num_words_lp * width_p;
  localparam int cnt_width_lp = (num_words_lp > 1) ? $clog2(num_words_lp) : 1;
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(num_words_lp - 1);

  logic [0:0]              state_d, state_q;
  logic                    ready_d, ready_q;
  logic [n_lp-1:0]         snapshot_d, snapshot_q;
  logic                    cnt_clear;
  logic                    cnt_up;
  logic [cnt_width_lp-1:0] cnt;
  logic                    is_last;
  logic [pad_width_lp-1:0] padded;
  logic [pad_width_lp-1:0] shifted;
  int unsigned             sel;

  bsg_counter_clear_up #(
    .max_val_p (num_words_lp - 1),
    .width_p   (cnt_width_lp)
  ) word_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (cnt_clear),
    .up_i      (cnt_up),
    .count_o   (cnt)
  );

  assign v_o     = (state_q == STATE_SEND);
  assign is_last = (cnt == last_cnt_lp);
  assign last_o  = v_o && is_last;
  assign ready_o = ready_q;

  always_comb begin
    state_d    = state_q;
    snapshot_d = snapshot_q;
    cnt_clear  = 1'b0;
    cnt_up     = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        // ready_q gates the capture so the first post-reset edge, where the
        // state is already IDLE but ready has not yet risen, is ignored.
        if (v_i && ready_q) begin
          snapshot_d = data_i;
          cnt_clear  = 1'b1;
          state_d    = STATE_SEND;
        end
      end
      STATE_SEND: begin
        if (yumi_i) begin
          if (is_last) begin
            cnt_clear = 1'b1;
            state_d   = STATE_IDLE;
          end else begin
            cnt_up = 1'b1;
          end
        end
      end
      default: state_d = STATE_IDLE;
    endcase
    ready_d = (state_d == STATE_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= STATE_IDLE;
      ready_q    <= 1'b0;
      snapshot_q <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      snapshot_q <= snapshot_d;
    end
  end

  // Zero-extend the snapshot to a whole number of words, then shift the
  // selected word down to bit 0.
  always_comb begin
    padded            = '0;
    padded[n_lp-1:0]  = snapshot_q;
    sel               = 32'(cnt) * 32'(width_p);
    shifted           = padded >> sel;
    data_o            = v_o ? shifted[width_p-1:0] : '0;
  end

`ifndef SYNTHESIS
  a_yumi_needs_valid : assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
    else $error("bsg_cgol_board_reader: yumi_i asserted while v_o is low");
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_cgol_board_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_bsg_cgol_board_reader
// Purpose : Self-checking bench for bsg_cgol_board_reader. Two instances:
//           the default 8x8 board with 8-bit words, and a 5x5 board with
//           8-bit words whose last word is padded.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bsg_cgol_board_reader;

  logic        clk;
  logic        reset_n;
  logic [63:0] tb_data;
  logic        tb_v;
  logic        tb_yumi;
  logic        use_pad;

  logic [63:0] d_data_i;
  logic        d_v_i, d_ready_o, d_v_o, d_yumi_i, d_last_o;
  logic [7:0]  d_data_o;
  logic [24:0] p_data_i;
  logic        p_v_i, p_ready_o, p_v_o, p_yumi_i, p_last_o;
  logic [7:0]  p_data_o;

  logic        o_ready, o_v, o_last;
  logic [7:0]  o_data;

  int errs;
  int checks;

  assign d_data_i = tb_data;
  assign p_data_i = tb_data[24:0];
  assign d_v_i    = tb_v & ~use_pad;
  assign p_v_i    = tb_v & use_pad;
  assign d_yumi_i = tb_yumi & ~use_pad;
  assign p_yumi_i = tb_yumi & use_pad;
  assign o_ready  = use_pad ? p_ready_o : d_ready_o;
  assign o_v      = use_pad ? p_v_o : d_v_o;
  assign o_last   = use_pad ? p_last_o : d_last_o;
  assign o_data   = use_pad ? p_data_o : d_data_o;

  bsg_cgol_board_reader #(.board_width_p(8), .width_p(8)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .data_i(d_data_i), .v_i(d_v_i),
    .ready_o(d_ready_o), .data_o(d_data_o), .v_o(d_v_o), .yumi_i(d_yumi_i),
    .last_o(d_last_o)
  );

  bsg_cgol_board_reader #(.board_width_p(5), .width_p(8)) dut_pad (
    .clk_i(clk), .reset_n_i(reset_n), .data_i(p_data_i), .v_i(p_v_i),
    .ready_o(p_ready_o), .data_o(p_data_o), .v_o(p_v_o), .yumi_i(p_yumi_i),
    .last_o(p_last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: word w of a frame is the run of width cells starting
  // at cell w*width, with cells beyond the board reading as zero.
  function automatic logic [7:0] model_word(input logic [63:0] cells, input int n, input int w);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (w * 8 + k < n) r[k] = cells[w * 8 + k];
    end
    return r;
  endfunction

  task automatic wait_ready();
    int budget;
    budget = 0;
    while (!o_ready && budget < 20) begin
      tick();
      budget++;
    end
    check("ready_timeout", {63'd0, o_ready}, 64'd1);
  endtask

  // Capture a frame and drain it. stall_word/stall_cycles hold yumi low on
  // one word; iso drives all-ones and v_i during the frame.
  task automatic run_frame(input logic [63:0] pat, input int stall_word, input int stall_cycles,
                           input bit iso);
    int n;
    int nw;
    logic [7:0] exp;
    n  = use_pad ? 25 : 64;
    nw = (n + 7) / 8;
    wait_ready();
    tb_data = pat;
    tb_v    = 1'b1;
    tick();
    tb_v = 1'b0;
    if (iso) tb_data = '1;
    for (int w = 0; w < nw; w++) begin
      exp = model_word(pat, n, w);
      check("v_o", {63'd0, o_v}, 64'd1);
      check("data_o", {56'd0, o_data}, {56'd0, exp});
      check("last_o", {63'd0, o_last}, {63'd0, (w == nw - 1)});
      check("ready_busy", {63'd0, o_ready}, 64'd0);
      if (w == stall_word) begin
        tb_yumi = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          tb_v = iso;
          tick();
          check("hold_data", {56'd0, o_data}, {56'd0, exp});
          check("hold_v", {63'd0, o_v}, 64'd1);
        end
      end
      tb_yumi = 1'b1;
      tb_v    = iso && (w != nw - 1);
      tick();
      tb_yumi = 1'b0;
      tb_v    = 1'b0;
    end
    check("post_v", {63'd0, o_v}, 64'd0);
    check("post_last", {63'd0, o_last}, 64'd0);
    check("post_ready", {63'd0, o_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] pat;
    errs    = 0;
    checks  = 0;
    reset_n = 1'b0;
    tb_data = '0;
    tb_v    = 1'b0;
    tb_yumi = 1'b0;
    use_pad = 1'b0;

    // Reset state.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_v", {62'd0, d_v_o, p_v_o}, 64'd0);
      check("rst_ready", {62'd0, d_ready_o, p_ready_o}, 64'd0);
      check("rst_data", {48'd0, d_data_o, p_data_o}, 64'd0);
    end
    reset_n = 1'b1;
    tick();
    check("ready_after_rst", {62'd0, d_ready_o, p_ready_o}, 64'd3);

    // Diagonal-ish pattern: row r = 1<<r.
    for (int r = 0; r < 8; r++) pat[r*8 +: 8] = 8'h01 << r;
    run_frame(pat, -1, 0, 1'b0);
    run_frame(pat, 2, 3, 1'b0);
    run_frame(pat, 1, 2, 1'b1);

    // Mid-frame reset after three accepted words.
    wait_ready();
    tb_data = pat;
    tb_v    = 1'b1;
    tick();
    tb_v = 1'b0;
    for (int w = 0; w < 3; w++) begin
      check("mid_data", {56'd0, o_data}, {56'd0, model_word(pat, 64, w)});
      tb_yumi = 1'b1;
      tick();
      tb_yumi = 1'b0;
    end
    check("mid_v_before", {63'd0, o_v}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_v_async", {63'd0, o_v}, 64'd0);
    check("mid_ready_async", {63'd0, o_ready}, 64'd0);
    check("mid_data_async", {56'd0, o_data}, 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("mid_ready_rel", {63'd0, o_ready}, 64'd1);
    run_frame(64'h0000_0000_0000_00FF, -1, 0, 1'b0);

    // Padding on the 5x5 board.
    use_pad = 1'b1;
    run_frame(64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 1'b0);

    // Randomized frames on both boards.
    for (int i = 0; i < 12; i++) begin
      use_pad = ($urandom_range(0, 2) == 0);
      pat     = {$urandom, $urandom};
      run_frame(pat, int'($urandom_range(0, 8)), int'($urandom_range(0, 4)), $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
